// File: rtl/afifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter.
package afifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    // Round-robin successor: (idx + 1) mod n, without a divider.
    function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request scanning from ptr upward, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] sel
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             idx;

    // Rotate the doubled request vector down by ptr, then priority-encode the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = N'(dbl);
        found = |rot;
        sel   = '0;
        idx   = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                idx = int'(ptr) + j;
                if (idx >= N) begin
                    idx = idx - N;
                end
                sel = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/afifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async FIFO write port among NUM_REQ requesters.
module afifo_write_arbiter
    import afifo_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_write_en,
    output logic [WIDTH-1:0]           fifo_write_data,
    output logic                       grant_active,
    output logic [ID_W-1:0]            grant_id,
    output logic [CNT_W-1:0]           burst_count
);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [CNT_W-1:0] burst_count_q, burst_count_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_sel;
    logic             owner_valid;
    logic             owner_last;
    logic [WIDTH-1:0] owner_data;
    logic             transfer;
    logic             cap_hit;

    // The pick only matters in IDLE, so req_valid never reaches req_ready combinationally there.
    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .sel   (pick_sel)
    );

    // Select the current owner's valid, last and data.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic and FIFO-side outputs; transfers only happen in BURST and never into a full FIFO.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id_q;
        burst_count_d   = burst_count_q;
        transfer        = 1'b0;
        fifo_write_en   = 1'b0;
        fifo_write_data = '0;
        req_ready       = '0;
        cap_hit         = (burst_count_q == CNT_W'(MAX_BURST - 1));
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_id_d    = pick_sel;
                    burst_count_d = '0;
                    state_d       = ARB_BURST;
                end
            end
            ARB_BURST: begin
                transfer        = owner_valid && !fifo_full;
                fifo_write_en   = transfer;
                fifo_write_data = owner_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = transfer && (grant_id_q == ID_W'(i));
                end
                if (transfer) begin
                    if (owner_last || cap_hit) begin
                        state_d       = ARB_IDLE;
                        rr_ptr_d      = ID_W'(next_rr(32'(grant_id_q), NUM_REQ));
                        burst_count_d = '0;
                    end else begin
                        burst_count_d = burst_count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers; an asynchronous reset abandons any partial burst at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            burst_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign grant_active = (state_q == ARB_BURST);
    assign grant_id     = grant_id_q;
    assign burst_count  = burst_count_q;

endmodule
